// File: rtl/transformer_host_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : transformer_host_if
//  Description : Element-stream bus of the transformer host. Input stream
//                (s_*) flows into the host, result stream (m_*) flows out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface transformer_host_if #(
   parameter int DATA_WIDTH = 16
);
   logic signed [DATA_WIDTH-1:0] s_data;
   logic                         s_valid;
   logic                         s_ready;
   logic signed [DATA_WIDTH-1:0] m_data;
   logic                         m_valid;
   logic                         m_ready;
   logic                         m_last;

   // Host side: consumes the input stream, produces the result stream.
   modport slave (
      input  s_data, s_valid, m_ready,
      output s_ready, m_data, m_valid, m_last
   );

   // Environment side: produces input elements, consumes results.
   modport master (
      output s_data, s_valid, m_ready,
      input  s_ready, m_data, m_valid, m_last
   );
endinterface
`default_nettype wire

// File: rtl/transformer_host.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : transformer_host
//  Description : Buffers one matrix from an element stream, hands it to a
//                compute core, waits (with timeout) for the result and
//                streams the result back out in row-major order.
//  Revision    : 1.0 - initial release
// ============================================================================
module transformer_host #(
   parameter int MATRIX_SIZE     = 64,
   parameter int DATA_WIDTH      = 16,
   parameter int MATRIX_ELEMENTS = MATRIX_SIZE * MATRIX_SIZE,
   parameter int TIMEOUT_CYCLES  = 1023
) (
   input  wire logic                         clk,
   input  wire logic                         rst_n,
   transformer_host_if.slave                 bus,
   output logic signed [DATA_WIDTH-1:0]      core_matrix_in [MATRIX_ELEMENTS],
   output logic                              core_matrix_valid,
   output logic                              core_compute_start,
   input  wire logic                         core_compute_done,
   input  wire logic                         core_matrix_ready,
   input  wire logic signed [DATA_WIDTH-1:0] core_matrix_out [MATRIX_ELEMENTS],
   output logic                              busy,
   output logic                              timeout
);

   localparam int IDX_W = (MATRIX_ELEMENTS > 1) ? $clog2(MATRIX_ELEMENTS) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_ELEMENTS - 1);
   localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      LOAD      = 3'd0,
      START     = 3'd1,
      WAIT_DONE = 3'd2,
      RELEASE   = 3'd3,
      UNLOAD    = 3'd4
   } state_t;

   state_t                       r_state;
   state_t                       w_state_next;
   logic [IDX_W-1:0]             r_wr_idx;
   logic [IDX_W-1:0]             r_rd_idx;
   logic [CNT_W-1:0]             r_cnt;
   logic [CNT_W-1:0]             w_cnt_inc;
   logic                         r_timeout;
   logic signed [DATA_WIDTH-1:0] r_buf [MATRIX_ELEMENTS];

   logic w_load_fire;
   logic w_load_last;
   logic w_unload_fire;
   logic w_unload_last;
   logic w_tmo_hit;

   // Saturating increment so the counter can never wrap while waiting.
   assign w_cnt_inc = (r_cnt == TMO_MAX) ? r_cnt : r_cnt + 1'b1;

   // State register; reset abandons whatever frame is in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= LOAD;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and all state-derived outputs.
   always_comb begin
      w_state_next       = r_state;
      w_load_fire        = 1'b0;
      w_load_last        = 1'b0;
      w_unload_fire      = 1'b0;
      w_unload_last      = 1'b0;
      w_tmo_hit          = 1'b0;
      bus.s_ready        = 1'b0;
      bus.m_valid        = 1'b0;
      bus.m_last         = 1'b0;
      core_compute_start = 1'b0;
      core_matrix_valid  = 1'b1;
      busy               = 1'b1;
      case (r_state)
         LOAD: begin
            bus.s_ready       = 1'b1;
            core_matrix_valid = 1'b0;
            busy              = 1'b0;
            w_load_fire       = bus.s_valid;
            w_load_last       = (r_wr_idx == LAST_IDX);
            if (w_load_fire && w_load_last) begin
               w_state_next = START;
            end
         end
         START: begin
            core_compute_start = 1'b1;
            w_state_next       = WAIT_DONE;
         end
         WAIT_DONE: begin
            core_compute_start = 1'b1;
            if (core_compute_done && core_matrix_ready) begin
               w_state_next = RELEASE;
            end else if (w_cnt_inc == TMO_MAX) begin
               w_tmo_hit    = 1'b1;
               w_state_next = LOAD;
            end
         end
         RELEASE: begin
            // Wait for the core to drop done so a stale flag cannot
            // be mistaken for the next frame's completion.
            if (!core_compute_done) begin
               w_state_next = UNLOAD;
            end
         end
         UNLOAD: begin
            bus.m_valid   = 1'b1;
            w_unload_last = (r_rd_idx == LAST_IDX);
            bus.m_last    = w_unload_last;
            w_unload_fire = bus.m_ready;
            if (w_unload_fire && w_unload_last) begin
               w_state_next = LOAD;
            end
         end
         default: begin
            w_state_next = LOAD;
         end
      endcase
   end

   // Write/read indices, timeout counter and the registered timeout pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_idx  <= '0;
         r_rd_idx  <= '0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_tmo_hit;
         if (w_load_fire) begin
            r_wr_idx <= w_load_last ? '0 : r_wr_idx + 1'b1;
         end else if (w_tmo_hit) begin
            r_wr_idx <= '0;
         end
         if (w_unload_fire) begin
            r_rd_idx <= w_unload_last ? '0 : r_rd_idx + 1'b1;
         end
         if (w_load_fire && w_load_last) begin
            r_cnt <= '0;
         end else if (r_state == WAIT_DONE) begin
            r_cnt <= w_cnt_inc;
         end
      end
   end

   // Matrix buffer: written only while loading, intentionally not reset.
   always_ff @(posedge clk) begin
      if (w_load_fire) begin
         r_buf[r_wr_idx] <= bus.s_data;
      end
   end

   assign core_matrix_in = r_buf;
   assign bus.m_data     = core_matrix_out[r_rd_idx];
   assign timeout        = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_transformer_host.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_transformer_host
//  Description : Self-checking bench for transformer_host with a behavioural
//                pass-through core and a queue-based result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_transformer_host;

   localparam int MS  = 64;
   localparam int DW  = 16;
   localparam int NE  = MS * MS;
   localparam int TMO = 1023;
   localparam int LAT = 33;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic signed [DW-1:0] core_matrix_in  [NE];
   logic signed [DW-1:0] core_matrix_out [NE];
   logic core_matrix_valid, core_compute_start, core_compute_done, core_matrix_ready;
   logic busy, timeout;

   transformer_host_if #(.DATA_WIDTH(DW)) bus ();

   transformer_host #(
      .MATRIX_SIZE     (MS),
      .DATA_WIDTH      (DW),
      .MATRIX_ELEMENTS (NE),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .bus                (bus.slave),
      .core_matrix_in     (core_matrix_in),
      .core_matrix_valid  (core_matrix_valid),
      .core_compute_start (core_compute_start),
      .core_compute_done  (core_compute_done),
      .core_matrix_ready  (core_matrix_ready),
      .core_matrix_out    (core_matrix_out),
      .busy               (busy),
      .timeout            (timeout)
   );

   int   n_total = 0;
   int   n_bad   = 0;
   int   cyc     = 0;
   exp_t exp_q [$];

   bit sink_en   = 1'b1;
   bit sink_rand = 1'b0;
   int out_idx   = 0;

   bit core_never_done = 1'b0;
   int core_hold       = 0;
   int done_fall_cyc   = 0;

   int start_rises  = 0;
   int start_cyc    = 0;
   int tmo_cycles   = 0;
   int tmo_cyc      = 0;
   int mvalid_seen  = 0;
   int first_mv_cyc = -1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Result sink: pops the scoreboard on every accepted beat.
   initial begin : sink
      logic          prev_stall;
      logic [DW-1:0] prev_data;
      exp_t          e;
      prev_stall  = 1'b0;
      prev_data   = '0;
      bus.m_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall  = 1'b0;
            bus.m_ready = 1'b0;
         end else begin
            if (prev_stall) begin
               check_val("stall_valid", 32'(bus.m_valid), 32'd1);
               check_val("stall_data", {16'h0, bus.m_data}, {16'h0, prev_data});
            end
            bus.m_ready = sink_en && (!sink_rand || ($urandom_range(0, 3) != 0));
            if (bus.m_valid && exp_q.size() == 0) begin
               check_val("spurious_m_valid", 32'(bus.m_valid), 32'd0);
            end else if (bus.m_valid && bus.m_ready) begin
               e = exp_q.pop_front();
               check_val("m_data", {16'h0, bus.m_data}, {16'h0, e.data});
               check_val("m_last", 32'(bus.m_last), 32'(e.last));
               out_idx++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
         end
      end
   end

   // Event monitor for start rises, timeout pulses and result activity.
   initial begin : monitor
      logic prev_start;
      prev_start = 1'b0;
      forever begin
         @(negedge clk);
         if (core_compute_start && !prev_start) begin
            start_rises++;
            start_cyc = cyc;
         end
         prev_start = core_compute_start;
         if (timeout) begin
            tmo_cycles++;
            tmo_cyc = cyc;
         end
         if (bus.m_valid) begin
            mvalid_seen++;
            if (first_mv_cyc < 0) first_mv_cyc = cyc;
         end
      end
   end

   // Pass-through core: copies the matrix LAT cycles after start.
   initial begin : core
      logic c_prev;
      bit   alive;
      int   g;
      c_prev            = 1'b0;
      core_compute_done = 1'b0;
      core_matrix_ready = 1'b0;
      for (int i = 0; i < NE; i++) core_matrix_out[i] = '0;
      forever begin
         @(negedge clk);
         if (core_compute_start && !c_prev && !core_never_done) begin
            alive = 1'b1;
            for (int k = 0; k < LAT; k++) begin
               @(negedge clk);
               if (!core_compute_start) begin
                  alive = 1'b0;
                  break;
               end
            end
            if (alive) begin
               check_val("core_mvalid", 32'(core_matrix_valid), 32'd1);
               for (int i = 0; i < NE; i++) core_matrix_out[i] = core_matrix_in[i];
               core_compute_done = 1'b1;
               core_matrix_ready = 1'b1;
               g = 0;
               do begin
                  @(negedge clk);
                  g++;
               end while (core_compute_start && g < 100);
               check_val("start_drop", 32'(core_compute_start), 32'd0);
               repeat (core_hold) @(negedge clk);
               core_compute_done = 1'b0;
               core_matrix_ready = 1'b0;
               done_fall_cyc     = cyc;
            end
         end
         c_prev = core_compute_start;
      end
   end

   task automatic load_frame(input bit use_fill, input logic [DW-1:0] fill,
                             input bit rand_gap, input bit push);
      exp_t          e;
      int            g;
      logic [DW-1:0] v;
      for (int i = 0; i < NE; i++) begin
         v = use_fill ? fill : DW'(i);
         if (rand_gap) begin
            while ($urandom_range(0, 3) == 0) begin
               bus.s_valid = 1'b0;
               @(negedge clk);
            end
         end
         bus.s_valid = 1'b1;
         bus.s_data  = v;
         g = 0;
         while (!bus.s_ready && g < 20000) begin
            @(negedge clk);
            g++;
         end
         if (!bus.s_ready) begin
            check_val("load_ready", 32'(bus.s_ready), 32'd1);
            bus.s_valid = 1'b0;
            return;
         end
         @(negedge clk);
         if (push) begin
            e.data = v;
            e.last = (i == NE - 1);
            exp_q.push_back(e);
         end
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int g;
      g = 0;
      while ((exp_q.size() != 0 || busy) && g < 30000) begin
         @(negedge clk);
         g++;
      end
      check_val(tag, 32'(exp_q.size()), 32'd0);
      check_val({tag, "_idle"}, 32'(busy), 32'd0);
      check_val({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
   endtask

   initial begin : main
      int sr0, tc0, mv0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      rst_n       = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_s_ready", 32'(bus.s_ready), 32'd1);
      check_val("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check_val("rst_m_last", 32'(bus.m_last), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_timeout", 32'(timeout), 32'd0);
      check_val("rst_start", 32'(core_compute_start), 32'd0);
      check_val("rst_mat_valid", 32'(core_matrix_valid), 32'd0);
      rst_n = 1'b1;

      // Ramp frame, continuous valid and ready.
      sr0 = start_rises;
      first_mv_cyc = -1;
      load_frame(1'b0, '0, 1'b0, 1'b1);
      wait_drain("ramp");
      check_val("ramp_starts", 32'(start_rises - sr0), 32'd1);
      check_val("ramp_first_mv", 32'(first_mv_cyc), 32'(done_fall_cyc + 1));

      // Ramp frame with random gaps on both handshakes.
      sr0 = start_rises;
      sink_rand = 1'b1;
      load_frame(1'b0, '0, 1'b1, 1'b1);
      wait_drain("rand");
      sink_rand = 1'b0;
      check_val("rand_starts", 32'(start_rises - sr0), 32'd1);

      // Core never finishes: expect a single timeout pulse.
      core_never_done = 1'b1;
      sr0 = start_rises;
      tc0 = tmo_cycles;
      mv0 = mvalid_seen;
      load_frame(1'b0, '0, 1'b0, 1'b0);
      for (int g = 0; g < 3000 && tmo_cycles == tc0; g++) begin
         @(negedge clk);
         #1;
      end
      check_val("tmo_seen", 32'(tmo_cycles - tc0), 32'd1);
      check_val("tmo_delay", 32'(tmo_cyc - start_cyc), 32'(TMO + 1));
      check_val("tmo_s_ready", 32'(bus.s_ready), 32'd1);
      check_val("tmo_busy", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      #1;
      check_val("tmo_pulse_len", 32'(tmo_cycles - tc0), 32'd1);
      check_val("tmo_no_m_valid", 32'(mvalid_seen - mv0), 32'd0);
      check_val("tmo_starts", 32'(start_rises - sr0), 32'd1);
      core_never_done = 1'b0;

      // Core keeps done high after start drops.
      core_hold = 3;
      first_mv_cyc = -1;
      load_frame(1'b0, '0, 1'b0, 1'b1);
      wait_drain("hold");
      check_val("hold_first_mv", 32'(first_mv_cyc), 32'(done_fall_cyc + 1));
      core_hold = 0;

      // Reset in the middle of unloading.
      out_idx = 0;
      load_frame(1'b0, '0, 1'b0, 1'b1);
      fork
         begin wait (out_idx >= 100); end
         begin repeat (20000) @(posedge clk); end
      join_any
      disable fork;
      sink_en = 1'b0;
      check_val("rst_reach", 32'(out_idx), 32'd100);
      @(posedge clk);
      #3;
      check_val("pre_rst_valid", 32'(bus.m_valid), 32'd1);
      check_val("pre_rst_data", {16'h0, bus.m_data}, 32'd100);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
      check_val("mid_rst_start", 32'(core_compute_start), 32'd0);
      check_val("mid_rst_busy", 32'(busy), 32'd0);
      check_val("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
      exp_q.delete();
      out_idx = 0;
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      sink_en = 1'b1;
      sr0 = start_rises;
      load_frame(1'b0, '0, 1'b0, 1'b1);
      wait_drain("after_rst");
      check_val("after_rst_starts", 32'(start_rises - sr0), 32'd1);

      // Back-to-back saturated frames.
      sr0 = start_rises;
      load_frame(1'b1, 16'h7FFF, 1'b0, 1'b1);
      load_frame(1'b1, 16'h8000, 1'b0, 1'b1);
      wait_drain("b2b");
      check_val("b2b_starts", 32'(start_rises - sr0), 32'd2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
